// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word fetches over req/gnt/rvalid,
// and hands a registered {instr, pc, pc+4} entry to decode under valid/ready, with branch redirect.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            b_sel,
  input  logic [XLEN-1:0] b_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pcp,
  input  logic            if_ready
);

  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } fetch_state_e;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req;
  logic [XLEN-1:0] r_addr;
  logic            r_discard;
  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_pcp;

  logic [XLEN-1:0] w_target_pc;
  logic [XLEN-1:0] w_issue_pc;
  logic            w_slot_free;
  logic            w_accept;
  logic            w_resp;
  logic            w_keep;

  // Redirect targets are always word aligned; the low two bits are forced to zero.
  assign w_target_pc = b_target & ~XLEN'(3);
  // A request issued this cycle must already use a redirect target arriving in the same cycle.
  assign w_issue_pc  = b_sel ? w_target_pc : r_pc;
  // The output slot is free next cycle if it is empty, being consumed, or being flushed.
  assign w_slot_free = !r_valid || if_ready || b_sel;
  assign w_accept    = r_valid && if_ready;
  // Responses outside WAIT have no outstanding request and are ignored.
  assign w_resp      = (r_state == S_WAIT) && imem_rvalid;
  assign w_keep      = w_resp && !r_discard && !b_sel;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_req     <= 1'b0;
      r_addr    <= RESET_PC;
      r_discard <= 1'b0;
      r_valid   <= 1'b0;
      r_instr   <= NOP_INSTR;
      r_if_pc   <= RESET_PC;
      r_if_pcp  <= RESET_PC + PC_STEP;
    end else begin
      // Output slot: a redirect drops the entry even if decode is accepting it.
      if (b_sel) begin
        r_valid <= 1'b0;
      end else if (w_keep) begin
        r_valid  <= 1'b1;
        r_instr  <= imem_rdata;
        r_if_pc  <= r_addr;
        r_if_pcp <= r_addr + PC_STEP;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (b_sel) begin
        r_pc <= w_target_pc;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_slot_free) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_addr  <= w_issue_pc;
          end
        end

        S_REQ: begin
          // A held request that a redirect overtook is still completed, then thrown away.
          if (b_sel) begin
            r_discard <= 1'b1;
          end
          if (imem_gnt) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
            if (!b_sel && !r_discard) begin
              r_pc <= r_pc + PC_STEP;
            end
          end
        end

        S_WAIT: begin
          if (imem_rvalid) begin
            r_discard <= 1'b0;
            if (w_keep || !w_slot_free) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_addr  <= w_issue_pc;
            end
          end else if (b_sel) begin
            r_discard <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = r_valid;
  assign if_instr  = r_instr;
  assign if_pc     = r_if_pc;
  assign if_pcp    = r_if_pcp;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction memory with programmable response delay
// drives the fetch port while scenario tasks check handshakes, redirects, wrap and reset.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_sel = 1'b0;
  logic [31:0] b_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcp;
  logic        if_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .b_sel       (b_sel),
    .b_target    (b_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pcp      (if_pcp),
    .if_ready    (if_ready)
  );

  always #5 clk = ~clk;

  // Memory content: address 0 holds 0x00500093; other words differ by their address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ a;
  endfunction

  // Memory model: grants immediately, answers rv_delay cycles after the cycle following gnt.
  int          rv_delay = 0;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      pend        = 1'b0;
      pend_cnt    = 0;
    end else begin
      imem_rvalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          pend        = 1'b0;
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end else begin
          pend_cnt--;
        end
      end
      imem_gnt = imem_req && !pend && !imem_rvalid;
      if (imem_gnt) begin
        pend      = 1'b1;
        pend_cnt  = rv_delay;
        pend_addr = imem_addr;
      end
    end
  end

  // Protocol watch: a response must always belong to a granted request.
  bit outstanding;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= 1'b0;
    end else begin
      if (imem_rvalid) begin
        assert (outstanding) else $error("imem_rvalid without an outstanding request");
        outstanding <= 1'b0;
      end
      if (imem_req && imem_gnt) outstanding <= 1'b1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    b_sel = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (if_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if ({imem_req, if_valid} !== 2'b00 || imem_addr !== RESET_PC || if_instr !== NOP ||
        if_pc !== RESET_PC || if_pcp !== RESET_PC + 32'd4) begin
      errors++;
      $display("FAIL reset_values: req=%b valid=%b addr=%h instr=%h pc=%h pcp=%h, expected 0 0 %h %h %h %h",
               imem_req, if_valid, imem_addr, if_instr, if_pc, if_pcp, RESET_PC, NOP, RESET_PC, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_first_fetch();
    bit ok;
    if_ready = 1'b1;
    rv_delay = 0;
    do_reset();
    step();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req: valid=%b req=%b addr=%h, expected 0 1 00000000", if_valid, imem_req, imem_addr);
    end
    step();
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_wait: valid=%b, expected 0", if_valid);
    end
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_pcp !== 32'h4 || if_instr !== 32'h0050_0093) begin
      errors++;
      $display("FAIL first_entry: valid=%b pc=%h pcp=%h instr=%h, expected 1 00000000 00000004 00500093",
               if_valid, if_pc, if_pcp, if_instr);
    end
    // Steady state: next entry three cycles later.
    step();
    step();
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h0050_0097) begin
      errors++;
      $display("FAIL second_entry: valid=%b pc=%h instr=%h, expected 1 00000004 00500097", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_hold();
    logic [31:0] s_instr;
    logic [31:0] s_pc;
    logic [31:0] s_pcp;
    if_ready = 1'b0;
    rv_delay = 0;
    do_reset();
    step();
    step();
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
      errors++;
      $display("FAIL hold_first: valid=%b pc=%h, expected 1 00000000", if_valid, if_pc);
    end
    s_instr = 32'h0050_0093;
    s_pc    = 32'h0;
    s_pcp   = 32'h4;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (if_valid !== 1'b1 || if_instr !== s_instr || if_pc !== s_pc || if_pcp !== s_pcp || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: valid=%b instr=%h pc=%h pcp=%h req=%b, expected 1 %h %h %h 0",
                 i, if_valid, if_instr, if_pc, if_pcp, imem_req, s_instr, s_pc, s_pcp);
      end
    end
    if_ready = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL hold_release: valid=%b req=%b addr=%h, expected 0 1 00000004", if_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    if_ready = 1'b1;
    rv_delay = 0;
    do_reset();
    wait_valid(ok);
    wait_valid(ok);
    checks++;
    if (!ok || if_pc !== 32'h4) begin
      errors++;
      $display("FAIL rw_setup: ok=%b pc=%h, expected 1 00000004", ok, if_pc);
    end
    rv_delay = 2;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL rw_req8: req=%b addr=%h, expected 1 00000008", imem_req, imem_addr);
    end
    step();
    b_sel    = 1'b1;
    b_target = 32'h0000_0103;
    step();
    b_sel = 1'b0;
    step();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b0 || imem_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rw_drop_cycle: valid=%b req=%b rvalid=%b, expected 0 0 1", if_valid, imem_req, imem_rvalid);
    end
    rv_delay = 0;
    step();
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++;
      $display("FAIL rw_new_req: valid=%b req=%b addr=%h, expected 0 1 00000100", if_valid, imem_req, imem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || if_pc !== 32'h100 || if_pcp !== 32'h104 || if_instr !== 32'h0050_0193) begin
      errors++;
      $display("FAIL rw_target_entry: ok=%b pc=%h pcp=%h instr=%h, expected 1 00000100 00000104 00500193",
               ok, if_pc, if_pcp, if_instr);
    end
  endtask

  task automatic test_redirect_with_rvalid();
    bit ok;
    rv_delay = 1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_rvalid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rv_wait: no imem_rvalid within 20 cycles, expected one");
    end
    b_sel    = 1'b1;
    b_target = 32'h0000_0200;
    step();
    b_sel    = 1'b0;
    rv_delay = 0;
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL rv_collide: valid=%b req=%b addr=%h, expected 0 1 00000200", if_valid, imem_req, imem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || if_pc !== 32'h200) begin
      errors++;
      $display("FAIL rv_next_entry: ok=%b pc=%h, expected 1 00000200", ok, if_pc);
    end
    // A valid entry is flushed by a redirect even while decode accepts it.
    if_ready = 1'b0;
    step();
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      errors++;
      $display("FAIL rv_held: valid=%b pc=%h, expected 1 00000200", if_valid, if_pc);
    end
    b_sel    = 1'b1;
    b_target = 32'h0000_0300;
    if_ready = 1'b1;
    step();
    b_sel = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      errors++;
      $display("FAIL rv_flush_entry: valid=%b req=%b addr=%h, expected 0 1 00000300", if_valid, imem_req, imem_addr);
    end
    wait_valid(ok);
    checks++;
    if (!ok || if_pc !== 32'h300) begin
      errors++;
      $display("FAIL rv_after_flush: ok=%b pc=%h, expected 1 00000300", ok, if_pc);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    b_sel    = 1'b1;
    b_target = 32'hFFFF_FFFF;
    step();
    b_sel = 1'b0;
    wait_valid(ok);
    checks++;
    if (!ok || if_pc !== 32'hFFFF_FFFC || if_pcp !== 32'h0 || if_instr !== 32'hFFAF_FF6F) begin
      errors++;
      $display("FAIL wrap_entry: ok=%b pc=%h pcp=%h instr=%h, expected 1 fffffffc 00000000 ffafff6f",
               ok, if_pc, if_pcp, if_instr);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next_addr: req=%b addr=%h, expected 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    rv_delay = 3;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req && imem_gnt) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    checks++;
    if (!ok || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_setup: granted=%b req=%b, expected 1 0", ok, imem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, if_valid} !== 2'b00 || imem_addr !== RESET_PC || if_instr !== NOP ||
        if_pc !== RESET_PC || if_pcp !== RESET_PC + 32'd4) begin
      errors++;
      $display("FAIL rst_async: req=%b valid=%b addr=%h instr=%h pc=%h pcp=%h, expected 0 0 %h %h %h %h",
               imem_req, if_valid, imem_addr, if_instr, if_pc, if_pcp, RESET_PC, NOP, RESET_PC, RESET_PC + 32'd4);
    end
    rv_delay = 0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rst_restart: req=%b addr=%h, expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
    wait_valid(ok);
    checks++;
    if (!ok || if_pc !== RESET_PC || if_instr !== 32'h0050_0093) begin
      errors++;
      $display("FAIL rst_entry: ok=%b pc=%h instr=%h, expected 1 %h 00500093", ok, if_pc, if_instr, RESET_PC);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold();
    test_redirect_wait();
    test_redirect_with_rvalid();
    test_wrap();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
